// File: rtl/booth_mac_sequencer.sv
// booth_mac_sequencer
//   Sequencing and accumulate stage that sits around a combinational 8x8 signed
//   multiplier. It accepts a vector of signed operand pairs, registers each
//   pair into the multiplier, and adds every returned product into a saturating
//   signed accumulator. The finished dot product is offered on an output
//   handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready depends only on the FSM state
// and never on in_valid. out_valid, result and sat do not change while
// out_valid=1 and out_ready=0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, len        begin a dot product of len pairs (sampled only in IDLE)
//   in_valid/in_ready operand pair handshake, pair on in_x/in_y
//   mul_x, mul_y      registered operands driven to the multiplier
//   mul_p             16-bit signed product returned by the multiplier
//   out_valid/ready   result handshake
//   result, sat       accumulated sum and sticky saturation flag
//   busy              high in every state except IDLE
//   dbg_state         current FSM state, for debug and checkers
module booth_mac_sequencer #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    output logic [7:0]       mul_x,
    output logic [7:0]       mul_y,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             sat,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [ACC_W-1:0]   r_acc;
    logic               r_sat;
    logic [7:0]         r_mul_x;
    logic [7:0]         r_mul_y;
    logic [LEN_W-1:0]   r_count;
    logic               r_p_vld;

    logic               w_accept;
    logic [ACC_W:0]     w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_clip;

    assign w_accept = (r_state == S_RUN) && in_valid;

    // Sum one bit wider than the accumulator; the top two bits disagree
    // exactly when the ACC_W-bit signed result would have wrapped.
    assign w_sum = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-15){mul_p[15]}}, mul_p};
    assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_clip = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            if (w_sum[ACC_W]) begin
                w_clip = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_clip = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // The beat that carries count==1 is the last of the vector.
                if (in_valid && (r_count == LEN_W'(1))) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_mul_x <= '0;
            r_mul_y <= '0;
            r_count <= '0;
            r_p_vld <= 1'b0;
        end else begin
            // The product of a registered pair is consumed on the next edge.
            r_p_vld <= w_accept;
            if (w_accept) begin
                r_mul_x <= in_x;
                r_mul_y <= in_y;
                r_count <= r_count - LEN_W'(1);
            end
            if ((r_state == S_IDLE) && start) begin
                r_acc <= '0;
                r_sat <= 1'b0;
                if (len != '0) begin
                    r_count <= len;
                end
            end else if (r_p_vld) begin
                r_acc <= w_clip;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign result    = r_acc;
    assign sat       = r_sat;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Bench for booth_mac_sequencer. Two instances (ACC_W=24 and ACC_W=17) share
// all inputs; each gets an ideal combinational multiplier. A plain-arithmetic
// dot-product model fills one expected queue per instance, and a negedge
// compare process checks result/sat whenever out_valid is high.
module tb_booth_mac_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        out_ready;

    logic        in_ready24, out_valid24, sat24, busy24;
    logic [7:0]  mul_x24, mul_y24;
    logic [15:0] mul_p24;
    logic [23:0] res24;
    logic [1:0]  dbg24;

    logic        in_ready17, out_valid17, sat17, busy17;
    logic [7:0]  mul_x17, mul_y17;
    logic [15:0] mul_p17;
    logic [16:0] res17;
    logic [1:0]  dbg17;

    logic [24:0] exp24_q[$];
    logic [17:0] exp17_q[$];
    byte         vx[$];
    byte         vy[$];

    logic [24:0] cap24;
    logic [17:0] cap17;

    int tests_run = 0;
    int fails = 0;

    booth_mac_sequencer #(.ACC_W(24), .LEN_W(8)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready24), .in_x(in_x), .in_y(in_y),
        .mul_x(mul_x24), .mul_y(mul_y24), .mul_p(mul_p24),
        .out_valid(out_valid24), .out_ready(out_ready), .result(res24),
        .sat(sat24), .busy(busy24), .dbg_state(dbg24)
    );

    booth_mac_sequencer #(.ACC_W(17), .LEN_W(8)) dut17 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready17), .in_x(in_x), .in_y(in_y),
        .mul_x(mul_x17), .mul_y(mul_y17), .mul_p(mul_p17),
        .out_valid(out_valid17), .out_ready(out_ready), .result(res17),
        .sat(sat17), .busy(busy17), .dbg_state(dbg17)
    );

    // Ideal multipliers: sign-extend to 16 bits, keep the low 16 bits.
    assign mul_p24 = 16'({{8{mul_x24[7]}}, mul_x24} * {{8{mul_y24[7]}}, mul_y24});
    assign mul_p17 = 16'({{8{mul_x17[7]}}, mul_x17} * {{8{mul_y17[7]}}, mul_y17});

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: saturating dot product over vx/vy at a given width.
    task automatic model(input int accw, output logic [63:0] res, output logic s);
        longint acc;
        longint hi;
        longint lo;
        acc = 0;
        s = 1'b0;
        hi = (longint'(1) <<< (accw - 1)) - 1;
        lo = -(longint'(1) <<< (accw - 1));
        for (int i = 0; i < vx.size(); i++) begin
            acc = acc + longint'(vx[i]) * longint'(vy[i]);
            if (acc > hi) begin acc = hi; s = 1'b1; end
            if (acc < lo) begin acc = lo; s = 1'b1; end
        end
        res = 64'(acc);
    endtask

    task automatic push_expected();
        logic [63:0] r;
        logic        s;
        model(24, r, s);
        exp24_q.push_back({s, r[23:0]});
        model(17, r, s);
        exp17_q.push_back({s, r[16:0]});
    endtask

    task automatic fill_rand(input int n);
        vx.delete();
        vy.delete();
        for (int i = 0; i < n; i++) begin
            vx.push_back(byte'($urandom_range(0, 255)));
            vy.push_back(byte'($urandom_range(0, 255)));
        end
    endtask

    task automatic fill_const(input int n, input byte x, input byte y);
        vx.delete();
        vy.delete();
        for (int i = 0; i < n; i++) begin
            vx.push_back(x);
            vy.push_back(y);
        end
    endtask

    // Drive one vector from vx/vy. Entered and left at posedge+1.
    task automatic run_vec(input int gap_max, input int stall, input bit poke);
        int n;
        int gap;
        n = vx.size();
        push_expected();
        check("idle_busy", busy24, 0);
        start = 1'b1;
        len = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            check("len0_valid", out_valid24, 1);
            check("len0_no_ready", in_ready24, 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                gap = (gap_max > 0 && i > 0) ? $urandom_range(1, gap_max) : 0;
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_x = 8'($urandom_range(0, 255));
                    in_y = 8'($urandom_range(0, 255));
                    check("gap_ready", in_ready24, 1);
                    @(posedge clk); #1;
                end
                in_valid = 1'b1;
                in_x = vx[i];
                in_y = vy[i];
                check("run_ready24", in_ready24, 1);
                check("run_ready17", in_ready17, 1);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            check("drain_ready", in_ready24, 0);
            check("drain_valid", out_valid24, 0);
            check("drain_busy", busy24, 1);
            @(posedge clk); #1;
            check("latency24", out_valid24, 1);
            check("latency17", out_valid17, 1);
        end
        cap24 = {sat24, res24};
        cap17 = {sat17, res17};
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                len = 8'($urandom_range(0, 255));
                in_valid = 1'($urandom_range(0, 1));
                in_x = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_valid", out_valid24, 0);
        check("handoff_busy", busy24, 0);
    endtask

    // Scoreboard compare: result/sat whenever out_valid, pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid24) begin
                if (exp24_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL result24: got %0h with no result expected", {sat24, res24});
                end else begin
                    check("result24", {sat24, res24}, exp24_q[0]);
                    if (out_ready) void'(exp24_q.pop_front());
                end
            end
            if (out_valid17) begin
                if (exp17_q.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL result17: got %0h with no result expected", {sat17, res17});
                end else begin
                    check("result17", {sat17, res17}, exp17_q[0]);
                    if (out_ready) void'(exp17_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready24, 0);
        check("rst_out_valid", out_valid24, 0);
        check("rst_busy", busy24, 0);
        check("rst_sat", sat24, 0);
        check("rst_result", res24, 0);
        check("rst_mul", {mul_x24, mul_y24}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mixed-sign vector, gap-free
        vx = {3, -5, 7};
        vy = {4, 6, -8};
        run_vec(0, 0, 0);
        check("lit_m74_24", cap24, {1'b0, 24'hFFFFB6});
        check("lit_m74_17", cap17, {1'b0, 17'h1FFB6});

        // Single-pair extremes of the product range
        fill_const(1, -128, -128);
        run_vec(0, 2, 0);
        check("lit_max_prod", cap24, {1'b0, 24'h004000});
        fill_const(1, -128, 127);
        run_vec(0, 0, 0);
        check("lit_min_prod", cap24, {1'b0, 24'hFFC080});

        // Positive saturation on the narrow instance, sat sticky in IDLE
        fill_const(5, -128, -128);
        run_vec(0, 1, 0);
        check("lit_sat17", cap17, {1'b1, 17'h0FFFF});
        check("lit_nosat24", cap24, {1'b0, 24'h014000});
        check("sat17_sticky", sat17, 1);
        check("res17_held", res17, 17'h0FFFF);

        // Empty vector clears sat
        vx.delete();
        vy.delete();
        run_vec(0, 0, 0);
        check("lit_len0", cap17, 18'h0);

        // Negative saturation
        fill_const(6, -128, 127);
        run_vec(0, 0, 0);
        check("lit_negsat17", cap17, {1'b1, 17'h10000});
        check("lit_neg24", cap24, {1'b0, 24'hFE8300});

        // Same vector with input gaps and an output stall with start pokes
        vx = {3, -5, 7};
        vy = {4, 6, -8};
        run_vec(3, 5, 1);
        check("lit_gaps", cap24, {1'b0, 24'hFFFFB6});

        // Reset in the middle of a 4-beat run
        start = 1'b1;
        len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_x = 8'd10;
        in_y = 8'd10;
        @(posedge clk); #1;
        in_x = 8'd20;
        in_y = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", res24, 0);
        check("mid_rst_flags", {in_ready24, out_valid24, busy24, sat24}, 0);
        check("mid_rst_mul", {mul_x24, mul_y24}, 0);
        check("mid_rst_res17", res17, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vx = {1, 2};
        vy = {1, 2};
        run_vec(0, 0, 0);
        check("lit_after_rst", cap24, {1'b0, 24'd5});

        // Longest vector
        fill_rand(255);
        run_vec(0, 0, 0);

        // Randomized vectors
        for (int t = 0; t < 30; t++) begin
            fill_rand(($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 12));
            run_vec($urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue24_empty", exp24_q.size(), 0);
        check("queue17_empty", exp17_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
